gcd_host_ctrl: RTL

- Host-side initiator for the GCD calculator top module.
- Accepts operand pairs on an upstream valid/ready port and pushes them into the calculator's two input FIFOs, respecting full flags.
- Asserts go while work is outstanding, pops results from the output FIFO when non-empty, and presents them downstream on a valid/ready port.
- Replaces hand-driven FIFO strobes at system level.

---
 rtl/gcd_host_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/gcd_host_ctrl.sv
// gcd_host_ctrl: host-side initiator for the GCD calculator.
// Takes operand pairs from an upstream valid/ready port and writes them into
// the calculator's two input FIFOs together. It keeps go asserted while pairs
// are in flight, pops results from the output FIFO one at a time, and offers
// them on a downstream valid/ready port.
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   req_valid/req_ready   upstream handshake; req_a/req_b carry the operands
//   resp_valid/resp_ready downstream handshake; resp_data carries the GCD
//   wr_1/wr_2, in_1/in_2  input FIFO write strobes and data
//   full_1/full_2         input FIFO full flags
//   go                    calculator enable
//   rd_out, empty_out     output FIFO read strobe and empty flag
//   result                output FIFO read data
//   outstanding           pairs accepted upstream but not yet delivered
//   done_cnt              results delivered since reset (wraps)
module gcd_host_ctrl #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned MAX_OUT = 8,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             wr_1,
    output logic             wr_2,
    output logic [WIDTH-1:0] in_1,
    output logic [WIDTH-1:0] in_2,
    input  logic             full_1,
    input  logic             full_2,
    output logic             go,
    output logic             rd_out,
    input  logic             empty_out,
    input  logic [WIDTH-1:0] result,
    output logic [7:0]       outstanding,
    output logic [15:0]      done_cnt
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DONE_W = 16;
    localparam int unsigned LAT_W  = 2;

    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);
    localparam logic [LAT_W-1:0] RD_LAT_C  = LAT_W'(RD_LAT);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_HOLD = 2'd2
    } rd_state_t;

    rd_state_t         state, state_d;
    logic [LAT_W-1:0]  wait_cnt, wait_cnt_d;
    logic              rd_out_d;
    logic              resp_valid_d;
    logic [WIDTH-1:0]  resp_data_d;
    logic [DONE_W-1:0] done_cnt_d;
    logic [CNT_W-1:0]  outstanding_d;
    logic              accept;
    logic              resp_hs;

    // Upstream acceptance: both FIFOs must have room and the in-flight limit not reached.
    assign req_ready = reset && !full_1 && !full_2 && (outstanding < MAX_OUT_C);
    assign accept    = req_valid && req_ready;
    assign resp_hs   = resp_valid && resp_ready;

    // Write path: one registered strobe per accepted pair, both FIFOs together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_1 <= 1'b0;
            wr_2 <= 1'b0;
            in_1 <= '0;
            in_2 <= '0;
        end else begin
            wr_1 <= accept;
            wr_2 <= accept;
            if (accept) begin
                in_1 <= req_a;
                in_2 <= req_b;
            end
        end
    end

    // In-flight count: a result delivered with nothing counted leaves it at 0.
    always_comb begin
        outstanding_d = outstanding;
        if (accept && !resp_hs) begin
            outstanding_d = outstanding + CNT_W'(1);
        end else if (resp_hs && !accept && (outstanding != '0)) begin
            outstanding_d = outstanding - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
            go          <= 1'b0;
        end else begin
            outstanding <= outstanding_d;
            go          <= (outstanding != '0);
        end
    end

    // Read FSM state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= R_IDLE;
            wait_cnt   <= '0;
            rd_out     <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            done_cnt   <= '0;
        end else begin
            state      <= state_d;
            wait_cnt   <= wait_cnt_d;
            rd_out     <= rd_out_d;
            resp_valid <= resp_valid_d;
            resp_data  <= resp_data_d;
            done_cnt   <= done_cnt_d;
        end
    end

    // Read FSM next state. wait_cnt is 0 during the strobe cycle and the FIFO
    // data is valid once RD_LAT cycles have elapsed after the strobe, so
    // capture happens when the counter reaches RD_LAT.
    always_comb begin
        state_d      = state;
        wait_cnt_d   = wait_cnt;
        rd_out_d     = 1'b0;
        resp_valid_d = resp_valid;
        resp_data_d  = resp_data;
        done_cnt_d   = done_cnt;
        case (state)
            R_IDLE: begin
                if (!empty_out) begin
                    rd_out_d   = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = R_WAIT;
                end
            end
            R_WAIT: begin
                if (wait_cnt == RD_LAT_C) begin
                    resp_data_d  = result;
                    resp_valid_d = 1'b1;
                    state_d      = R_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt + LAT_W'(1);
                end
            end
            R_HOLD: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    done_cnt_d   = done_cnt + DONE_W'(1);
                    state_d      = R_IDLE;
                end
            end
            default: begin
                state_d = R_IDLE;
            end
        endcase
    end

endmodule
